// File: rtl/trap_sequencer.sv
// ============================================================================
// trap_sequencer : M-mode trap entry / MRET sequencer in front of the CSR file
// Revision 1.0 : initial release
// ============================================================================
`default_nettype none

package trap_sequencer_pkg;
  typedef enum logic [1:0] {
    NO_COMMAND = 2'd0,
    READ_ONLY  = 2'd1,
    WRITE_ONLY = 2'd2
  } csr_command_t;
endpackage

module trap_sequencer
  import trap_sequencer_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic               clock_i,
  input  logic               reset_ni,
  input  logic               exc_valid_i,
  input  logic [5:0]         exc_cause_i,
  input  logic [XLEN-1:0]    exc_pc_i,
  input  logic [XLEN-1:0]    exc_tval_i,
  input  logic               mret_i,
  input  logic               irq_meip_i,
  input  logic               irq_mtip_i,
  input  logic               irq_msip_i,
  input  logic               mie_meie_i,
  input  logic               mie_mtie_i,
  input  logic               mie_msie_i,
  input  logic               mstatus_mie_i,
  output logic [11:0]        csr_address_o,
  output csr_command_t       csr_command_o,
  output logic [XLEN-1:0]    csr_write_data_o,
  input  logic [XLEN-1:0]    csr_read_data_i,
  input  logic               csr_read_data_valid_i,
  output logic               trap_ack_o,
  output logic               stall_o,
  output logic               redirect_valid_o,
  output logic [XLEN-1:0]    redirect_pc_o
);

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_MTVAL   = 12'h343;

  localparam logic [5:0] CODE_MEI = 6'd11;
  localparam logic [5:0] CODE_MSI = 6'd3;
  localparam logic [5:0] CODE_MTI = 6'd7;

  typedef enum logic [3:0] {
    IDLE        = 4'd0,
    WR_EPC      = 4'd1,
    WR_CAUSE    = 4'd2,
    WR_TVAL     = 4'd3,
    RD_STATUS   = 4'd4,
    WR_STATUS   = 4'd5,
    RD_TVEC     = 4'd6,
    M_RD_EPC    = 4'd7,
    M_RD_STATUS = 4'd8,
    M_WR_STATUS = 4'd9,
    REDIRECT    = 4'd10
  } state_t;

  state_t            state;
  logic              intr;
  logic [5:0]        code;
  logic [XLEN-1:0]   pc;
  logic [XLEN-1:0]   tval;
  logic [XLEN-1:0]   status;
  logic [XLEN-1:0]   target;

  logic              idle;
  logic              meip_take;
  logic              msip_take;
  logic              mtip_take;
  logic              irq_take;
  logic              accept_exc;
  logic              accept_irq;
  logic              accept_mret;
  logic              accept_any;
  logic [5:0]        irq_code;
  logic              pc_lsb_unused;

  // Trap entry: MPIE <- MIE, MIE <- 0, MPP <- M.
  function automatic logic [XLEN-1:0] trap_status(input logic [XLEN-1:0] s);
    logic [XLEN-1:0] r;
    r        = s;
    r[7]     = s[3];
    r[3]     = 1'b0;
    r[12:11] = 2'b11;
    return r;
  endfunction

  // MRET: MIE <- MPIE, MPIE <- 1, MPP <- M.
  function automatic logic [XLEN-1:0] mret_status(input logic [XLEN-1:0] s);
    logic [XLEN-1:0] r;
    r        = s;
    r[3]     = s[7];
    r[7]     = 1'b1;
    r[12:11] = 2'b11;
    return r;
  endfunction

  // Vectored mode only applies to interrupts; modes 2/3 fall back to direct.
  function automatic logic [XLEN-1:0] trap_target(input logic [XLEN-1:0] tvec,
                                                  input logic            is_intr,
                                                  input logic [5:0]      cause);
    logic [XLEN-1:0] base;
    base = {tvec[XLEN-1:2], 2'b00};
    if (is_intr && (tvec[1:0] == 2'b01)) begin
      return base + {{(XLEN-8){1'b0}}, cause, 2'b00};
    end
    return base;
  endfunction

  assign idle        = (state == IDLE);
  assign meip_take   = mstatus_mie_i & mie_meie_i & irq_meip_i;
  assign msip_take   = mstatus_mie_i & mie_msie_i & irq_msip_i;
  assign mtip_take   = mstatus_mie_i & mie_mtie_i & irq_mtip_i;
  assign irq_take    = meip_take | msip_take | mtip_take;
  assign irq_code    = meip_take ? CODE_MEI : (msip_take ? CODE_MSI : CODE_MTI);

  assign accept_exc  = idle & exc_valid_i;
  assign accept_irq  = idle & ~exc_valid_i & irq_take;
  assign accept_mret = idle & ~exc_valid_i & ~irq_take & mret_i;
  assign accept_any  = accept_exc | accept_irq | accept_mret;

  // Gated by reset so every output reads zero while reset is held.
  assign trap_ack_o  = reset_ni & accept_any;

  assign pc_lsb_unused = pc[0];

  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state            <= IDLE;
      intr             <= 1'b0;
      code             <= '0;
      pc               <= '0;
      tval             <= '0;
      status           <= '0;
      target           <= '0;
      stall_o          <= 1'b0;
      redirect_valid_o <= 1'b0;
      redirect_pc_o    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept_any) begin
            intr    <= accept_irq;
            code    <= accept_exc ? exc_cause_i : (accept_irq ? irq_code : 6'd0);
            pc      <= accept_mret ? '0 : exc_pc_i;
            tval    <= accept_exc ? exc_tval_i : '0;
            stall_o <= 1'b1;
            state   <= accept_mret ? M_RD_EPC : WR_EPC;
          end
        end
        WR_EPC:    state <= WR_CAUSE;
        WR_CAUSE:  state <= WR_TVAL;
        WR_TVAL:   state <= RD_STATUS;
        RD_STATUS: begin
          if (csr_read_data_valid_i) begin
            status <= csr_read_data_i;
            state  <= WR_STATUS;
          end
        end
        WR_STATUS: state <= RD_TVEC;
        RD_TVEC: begin
          if (csr_read_data_valid_i) begin
            target           <= trap_target(csr_read_data_i, intr, code);
            redirect_pc_o    <= trap_target(csr_read_data_i, intr, code);
            redirect_valid_o <= 1'b1;
            state            <= REDIRECT;
          end
        end
        M_RD_EPC: begin
          if (csr_read_data_valid_i) begin
            target <= csr_read_data_i;
            state  <= M_RD_STATUS;
          end
        end
        M_RD_STATUS: begin
          if (csr_read_data_valid_i) begin
            status <= csr_read_data_i;
            state  <= M_WR_STATUS;
          end
        end
        M_WR_STATUS: begin
          redirect_pc_o    <= target;
          redirect_valid_o <= 1'b1;
          state            <= REDIRECT;
        end
        REDIRECT: begin
          redirect_pc_o    <= '0;
          redirect_valid_o <= 1'b0;
          stall_o          <= 1'b0;
          state            <= IDLE;
        end
        default: begin
          redirect_pc_o    <= '0;
          redirect_valid_o <= 1'b0;
          stall_o          <= 1'b0;
          state            <= IDLE;
        end
      endcase
    end
  end

  // CSR port is decoded purely from registered state; reads repeat while data is not valid.
  always_comb begin
    csr_command_o    = NO_COMMAND;
    csr_address_o    = '0;
    csr_write_data_o = '0;
    case (state)
      WR_EPC: begin
        csr_command_o    = WRITE_ONLY;
        csr_address_o    = CSR_MEPC;
        csr_write_data_o = {pc[XLEN-1:1], 1'b0};
      end
      WR_CAUSE: begin
        csr_command_o    = WRITE_ONLY;
        csr_address_o    = CSR_MCAUSE;
        csr_write_data_o = {intr, {(XLEN-7){1'b0}}, code};
      end
      WR_TVAL: begin
        csr_command_o    = WRITE_ONLY;
        csr_address_o    = CSR_MTVAL;
        csr_write_data_o = tval;
      end
      RD_STATUS, M_RD_STATUS: begin
        csr_command_o    = READ_ONLY;
        csr_address_o    = CSR_MSTATUS;
      end
      WR_STATUS: begin
        csr_command_o    = WRITE_ONLY;
        csr_address_o    = CSR_MSTATUS;
        csr_write_data_o = trap_status(status);
      end
      RD_TVEC: begin
        csr_command_o    = READ_ONLY;
        csr_address_o    = CSR_MTVEC;
      end
      M_RD_EPC: begin
        csr_command_o    = READ_ONLY;
        csr_address_o    = CSR_MEPC;
      end
      M_WR_STATUS: begin
        csr_command_o    = WRITE_ONLY;
        csr_address_o    = CSR_MSTATUS;
        csr_write_data_o = mret_status(status);
      end
      default: begin
        csr_command_o    = NO_COMMAND;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_trap_sequencer.sv
// ============================================================================
// tb_trap_sequencer : directed self-checking bench for trap_sequencer
// Revision 1.0 : initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_trap_sequencer;
  import trap_sequencer_pkg::*;

  localparam int XLEN = 64;
  localparam logic [11:0] A_MSTATUS = 12'h300;
  localparam logic [11:0] A_MTVEC   = 12'h305;
  localparam logic [11:0] A_MEPC    = 12'h341;
  localparam logic [11:0] A_MCAUSE  = 12'h342;
  localparam logic [11:0] A_MTVAL   = 12'h343;

  logic              clock_i = 1'b0;
  logic              reset_ni;
  logic              exc_valid_i;
  logic [5:0]        exc_cause_i;
  logic [XLEN-1:0]   exc_pc_i;
  logic [XLEN-1:0]   exc_tval_i;
  logic              mret_i;
  logic              irq_meip_i, irq_mtip_i, irq_msip_i;
  logic              mie_meie_i, mie_mtie_i, mie_msie_i, mstatus_mie_i;
  logic [11:0]       csr_address_o;
  csr_command_t      csr_command_o;
  logic [XLEN-1:0]   csr_write_data_o;
  logic [XLEN-1:0]   csr_read_data_i;
  logic              csr_read_data_valid_i;
  logic              trap_ack_o;
  logic              stall_o;
  logic              redirect_valid_o;
  logic [XLEN-1:0]   redirect_pc_o;

  logic [XLEN-1:0]   tvec_val, status_val, epc_val;
  int                checks = 0;
  int                failures = 0;

  always #5 clock_i = ~clock_i;

  trap_sequencer #(.XLEN(XLEN)) dut (
    .clock_i               (clock_i),
    .reset_ni              (reset_ni),
    .exc_valid_i           (exc_valid_i),
    .exc_cause_i           (exc_cause_i),
    .exc_pc_i              (exc_pc_i),
    .exc_tval_i            (exc_tval_i),
    .mret_i                (mret_i),
    .irq_meip_i            (irq_meip_i),
    .irq_mtip_i            (irq_mtip_i),
    .irq_msip_i            (irq_msip_i),
    .mie_meie_i            (mie_meie_i),
    .mie_mtie_i            (mie_mtie_i),
    .mie_msie_i            (mie_msie_i),
    .mstatus_mie_i         (mstatus_mie_i),
    .csr_address_o         (csr_address_o),
    .csr_command_o         (csr_command_o),
    .csr_write_data_o      (csr_write_data_o),
    .csr_read_data_i       (csr_read_data_i),
    .csr_read_data_valid_i (csr_read_data_valid_i),
    .trap_ack_o            (trap_ack_o),
    .stall_o               (stall_o),
    .redirect_valid_o      (redirect_valid_o),
    .redirect_pc_o         (redirect_pc_o)
  );

  // Minimal CSR file: returns the preset value for the addressed register.
  always_comb begin
    csr_read_data_i = '0;
    case (csr_address_o)
      A_MTVEC:   csr_read_data_i = tvec_val;
      A_MSTATUS: csr_read_data_i = status_val;
      A_MEPC:    csr_read_data_i = epc_val;
      default:   csr_read_data_i = '0;
    endcase
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic next_cycle;
    @(posedge clock_i);
    #1;
  endtask

  task automatic clear_req;
    exc_valid_i = 1'b0;
    exc_cause_i = '0;
    exc_pc_i    = '0;
    exc_tval_i  = '0;
    mret_i      = 1'b0;
    irq_meip_i  = 1'b0;
    irq_mtip_i  = 1'b0;
    irq_msip_i  = 1'b0;
  endtask

  task automatic expect_out(input string tag, input csr_command_t cmd, input logic [11:0] addr,
                            input logic [63:0] data, input logic ack, input logic stall,
                            input logic rv, input logic [63:0] rpc);
    @(negedge clock_i);
    check({tag, ".cmd"},   64'(csr_command_o),    64'(cmd));
    check({tag, ".addr"},  64'(csr_address_o),    64'(addr));
    check({tag, ".wdata"}, csr_write_data_o,      data);
    check({tag, ".ack"},   64'(trap_ack_o),       64'(ack));
    check({tag, ".stall"}, 64'(stall_o),          64'(stall));
    check({tag, ".rv"},    64'(redirect_valid_o), 64'(rv));
    check({tag, ".rpc"},   redirect_pc_o,         rpc);
  endtask

  // Runs cycles 1..8 of a trap entry; requests are dropped in cycle 1.
  task automatic run_trap(input string tag, input logic [63:0] mepc, input logic [63:0] mcause,
                          input logic [63:0] mtval, input logic [63:0] mstatus_w,
                          input logic [63:0] rpc, input int hold);
    next_cycle; clear_req;
    expect_out({tag, "/c1"}, WRITE_ONLY, A_MEPC,    mepc,      1'b0, 1'b1, 1'b0, 64'h0);
    next_cycle;
    expect_out({tag, "/c2"}, WRITE_ONLY, A_MCAUSE,  mcause,    1'b0, 1'b1, 1'b0, 64'h0);
    next_cycle;
    expect_out({tag, "/c3"}, WRITE_ONLY, A_MTVAL,   mtval,     1'b0, 1'b1, 1'b0, 64'h0);
    next_cycle;
    expect_out({tag, "/c4"}, READ_ONLY,  A_MSTATUS, 64'h0,     1'b0, 1'b1, 1'b0, 64'h0);
    next_cycle;
    expect_out({tag, "/c5"}, WRITE_ONLY, A_MSTATUS, mstatus_w, 1'b0, 1'b1, 1'b0, 64'h0);
    for (int h = 0; h <= hold; h++) begin
      next_cycle;
      csr_read_data_valid_i = (h == hold);
      expect_out({tag, "/tvec"}, READ_ONLY, A_MTVEC, 64'h0, 1'b0, 1'b1, 1'b0, 64'h0);
    end
    next_cycle;
    csr_read_data_valid_i = 1'b1;
    expect_out({tag, "/redir"}, NO_COMMAND, 12'h0, 64'h0, 1'b0, 1'b1, 1'b1, rpc);
    next_cycle;
    expect_out({tag, "/idle"},  NO_COMMAND, 12'h0, 64'h0, 1'b0, 1'b0, 1'b0, 64'h0);
  endtask

  task automatic start_exc(input logic [5:0] cause, input logic [63:0] pc, input logic [63:0] tv);
    exc_valid_i = 1'b1;
    exc_cause_i = cause;
    exc_pc_i    = pc;
    exc_tval_i  = tv;
  endtask

  initial begin
    reset_ni = 1'b0;
    clear_req();
    mie_meie_i = 1'b0; mie_mtie_i = 1'b0; mie_msie_i = 1'b0; mstatus_mie_i = 1'b0;
    csr_read_data_valid_i = 1'b1;
    tvec_val = '0; status_val = '0; epc_val = '0;

    expect_out("reset", NO_COMMAND, 12'h0, 64'h0, 1'b0, 1'b0, 1'b0, 64'h0);
    next_cycle;
    reset_ni = 1'b1;

    // Exception, direct-mode mtvec with low bits set
    next_cycle;
    tvec_val = 64'h8000_0101; status_val = 64'h8;
    start_exc(6'd2, 64'h8000_0103, 64'h13);
    expect_out("exc/c0", NO_COMMAND, 12'h0, 64'h0, 1'b1, 1'b0, 1'b0, 64'h0);
    run_trap("exc", 64'h8000_0102, 64'h2, 64'h13, 64'h1880, 64'h8000_0100, 0);

    // Vectored timer interrupt; tval is forced to zero
    next_cycle;
    tvec_val = 64'h1001; status_val = 64'h8;
    mie_mtie_i = 1'b1; mstatus_mie_i = 1'b1;
    irq_mtip_i = 1'b1; exc_pc_i = 64'h4001; exc_tval_i = 64'h55;
    expect_out("mti/c0", NO_COMMAND, 12'h0, 64'h0, 1'b1, 1'b0, 1'b0, 64'h0);
    run_trap("mti", 64'h4000, 64'h8000_0000_0000_0007, 64'h0, 64'h1880, 64'h101C, 0);

    // Exception beats an enabled MEI and a same-cycle MRET
    next_cycle;
    mie_meie_i = 1'b1; status_val = 64'h0;
    start_exc(6'd5, 64'h1000, 64'h44);
    irq_meip_i = 1'b1; mret_i = 1'b1;
    expect_out("prio/c0", NO_COMMAND, 12'h0, 64'h0, 1'b1, 1'b0, 1'b0, 64'h0);
    run_trap("prio", 64'h1000, 64'h5, 64'h44, 64'h1800, 64'h1000, 0);
    next_cycle;
    expect_out("prio/nomret", NO_COMMAND, 12'h0, 64'h0, 1'b0, 1'b0, 1'b0, 64'h0);

    // MEI wins over MTI, vectored offset 11*4
    next_cycle;
    status_val = 64'h8;
    irq_meip_i = 1'b1; irq_mtip_i = 1'b1; exc_pc_i = 64'h3000;
    expect_out("mei/c0", NO_COMMAND, 12'h0, 64'h0, 1'b1, 1'b0, 1'b0, 64'h0);
    run_trap("mei", 64'h3000, 64'h8000_0000_0000_000B, 64'h0, 64'h1880, 64'h102C, 0);

    // MRET
    next_cycle;
    epc_val = 64'h2000; status_val = 64'h1880;
    mret_i = 1'b1;
    expect_out("mret/c0", NO_COMMAND, 12'h0, 64'h0, 1'b1, 1'b0, 1'b0, 64'h0);
    next_cycle; clear_req();
    expect_out("mret/c1", READ_ONLY,  A_MEPC,    64'h0,    1'b0, 1'b1, 1'b0, 64'h0);
    next_cycle;
    expect_out("mret/c2", READ_ONLY,  A_MSTATUS, 64'h0,    1'b0, 1'b1, 1'b0, 64'h0);
    next_cycle;
    expect_out("mret/c3", WRITE_ONLY, A_MSTATUS, 64'h1888, 1'b0, 1'b1, 1'b0, 64'h0);
    next_cycle;
    expect_out("mret/c4", NO_COMMAND, 12'h0,     64'h0,    1'b0, 1'b1, 1'b1, 64'h2000);
    next_cycle;
    expect_out("mret/c5", NO_COMMAND, 12'h0,     64'h0,    1'b0, 1'b0, 1'b0, 64'h0);

    // Global MIE clear masks a pending, enabled interrupt
    next_cycle;
    mstatus_mie_i = 1'b0; irq_mtip_i = 1'b1;
    expect_out("mask/c0", NO_COMMAND, 12'h0, 64'h0, 1'b0, 1'b0, 1'b0, 64'h0);
    next_cycle;
    expect_out("mask/c1", NO_COMMAND, 12'h0, 64'h0, 1'b0, 1'b0, 1'b0, 64'h0);
    clear_req();

    // mtvec read held invalid for two cycles: redirect moves to cycle 9
    next_cycle;
    tvec_val = 64'h0000_0000_0000_0200; status_val = 64'h0;
    start_exc(6'd7, 64'h500, 64'h0);
    expect_out("hold/c0", NO_COMMAND, 12'h0, 64'h0, 1'b1, 1'b0, 1'b0, 64'h0);
    run_trap("hold", 64'h500, 64'h7, 64'h0, 64'h1800, 64'h200, 2);

    // Asynchronous reset in WR_STATUS
    next_cycle;
    status_val = 64'h8; tvec_val = 64'h8000_0101;
    start_exc(6'd2, 64'h8000_0103, 64'h13);
    expect_out("rst/c0", NO_COMMAND, 12'h0, 64'h0, 1'b1, 1'b0, 1'b0, 64'h0);
    next_cycle; clear_req();
    next_cycle; next_cycle; next_cycle; next_cycle;
    expect_out("rst/c5", WRITE_ONLY, A_MSTATUS, 64'h1880, 1'b0, 1'b1, 1'b0, 64'h0);
    #2;
    reset_ni = 1'b0;
    #1;
    check("rst/now.cmd",   64'(csr_command_o),    64'(NO_COMMAND));
    check("rst/now.addr",  64'(csr_address_o),    64'h0);
    check("rst/now.wdata", csr_write_data_o,      64'h0);
    check("rst/now.stall", 64'(stall_o),          64'h0);
    check("rst/now.rv",    64'(redirect_valid_o), 64'h0);
    check("rst/now.ack",   64'(trap_ack_o),       64'h0);
    next_cycle;
    reset_ni = 1'b1;
    expect_out("rst/idle", NO_COMMAND, 12'h0, 64'h0, 1'b0, 1'b0, 1'b0, 64'h0);

    next_cycle;
    start_exc(6'd2, 64'h8000_0103, 64'h13);
    expect_out("post/c0", NO_COMMAND, 12'h0, 64'h0, 1'b1, 1'b0, 1'b0, 64'h0);
    run_trap("post", 64'h8000_0102, 64'h2, 64'h13, 64'h1880, 64'h8000_0100, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Hard stop in case a wait never completes.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish (got running, expected finished)");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
